// File: rtl/wb_scoreboard_rf_if.sv
// Decode/write-back port bundle for the scoreboarded register file.
// master = pipeline side (decode + write-back), slave = register file.
interface wb_scoreboard_rf_if;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_use_hi;
    logic        id_use_lo;
    logic        id_dst_rf;
    logic [4:0]  id_dst_idx;
    logic        id_dst_hi;
    logic        id_dst_lo;
    logic        id_stall;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_hi_data;
    logic [31:0] id_lo_data;
    logic        wb_retire;
    logic [6:0]  wb_tag;
    logic        rf_wena;
    logic        hi_wena;
    logic        lo_wena;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        sb_err;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_hi, id_use_lo,
               id_dst_rf, id_dst_idx, id_dst_hi, id_dst_lo,
               wb_retire, wb_tag, rf_wena, hi_wena, lo_wena,
               rf_waddr, rf_wdata, hi_wdata, lo_wdata,
        input  id_stall, id_rs_data, id_rt_data, id_hi_data, id_lo_data, sb_err
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_hi, id_use_lo,
               id_dst_rf, id_dst_idx, id_dst_hi, id_dst_lo,
               wb_retire, wb_tag, rf_wena, hi_wena, lo_wena,
               rf_waddr, rf_wdata, hi_wdata, lo_wdata,
        output id_stall, id_rs_data, id_rt_data, id_hi_data, id_lo_data, sb_err
    );
endinterface

// File: rtl/wb_scoreboard_rf.sv
// 32x32 GPR file plus HI/LO with per-register pending-writer counters.
// Decode stalls on pending sources; write-back data bypasses to the read ports.
module wb_scoreboard_rf (
    input  logic               clk,
    input  logic               rst,
    wb_scoreboard_rf_if.slave  bus
);

    logic [31:0] r_gpr [1:31];
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [1:0]  r_cnt [1:31];
    logic [1:0]  r_cnt_hi;
    logic [1:0]  r_cnt_lo;
    logic        r_sb_err;

    logic [1:0]  w_cnt_nxt [1:31];
    logic [1:0]  w_cnt_hi_nxt;
    logic [1:0]  w_cnt_lo_nxt;
    logic [1:0]  w_cnt_rs;
    logic [1:0]  w_cnt_rt;
    logic [1:0]  w_cnt_dst;
    logic [4:0]  w_tag_gpr;
    logic        w_dec_hi;
    logic        w_dec_lo;
    logic        w_blk_rs;
    logic        w_blk_rt;
    logic        w_blk_hi;
    logic        w_blk_lo;
    logic        w_full;
    logic        w_stall;
    logic        w_issue;
    logic        w_dec_err;
    logic        w_err;

    // Issue and retire on the same counter cancel out; a lone retire never wraps below 0.
    function automatic logic [1:0] f_cnt_step(input logic [1:0] cnt, input logic inc,
                                              input logic dec);
        if (inc && !dec && cnt != 2'd3) return cnt + 2'd1;
        if (dec && !inc && cnt != 2'd0) return cnt - 2'd1;
        return cnt;
    endfunction

    assign w_tag_gpr = bus.wb_tag[4:0];
    assign w_dec_hi  = bus.wb_retire && bus.wb_tag[5];
    assign w_dec_lo  = bus.wb_retire && bus.wb_tag[6];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_cnt_rs  = 2'd0;
        w_cnt_rt  = 2'd0;
        w_cnt_dst = 2'd0;
        if (bus.id_rs != 5'd0)      w_cnt_rs  = r_cnt[bus.id_rs];
        if (bus.id_rt != 5'd0)      w_cnt_rt  = r_cnt[bus.id_rt];
        if (bus.id_dst_idx != 5'd0) w_cnt_dst = r_cnt[bus.id_dst_idx];
    end

    // A pending source is released only by its last writer retiring with its enable high.
    assign w_blk_rs = bus.id_use_rs && (w_cnt_rs != 2'd0) &&
                      !(w_cnt_rs == 2'd1 && bus.wb_retire && w_tag_gpr == bus.id_rs && bus.rf_wena);
    assign w_blk_rt = bus.id_use_rt && (w_cnt_rt != 2'd0) &&
                      !(w_cnt_rt == 2'd1 && bus.wb_retire && w_tag_gpr == bus.id_rt && bus.rf_wena);
    assign w_blk_hi = bus.id_use_hi && (r_cnt_hi != 2'd0) &&
                      !(r_cnt_hi == 2'd1 && w_dec_hi && bus.hi_wena);
    assign w_blk_lo = bus.id_use_lo && (r_cnt_lo != 2'd0) &&
                      !(r_cnt_lo == 2'd1 && w_dec_lo && bus.lo_wena);

    assign w_full = (bus.id_dst_rf && w_cnt_dst == 2'd3 &&
                     !(bus.wb_retire && w_tag_gpr == bus.id_dst_idx)) ||
                    (bus.id_dst_hi && r_cnt_hi == 2'd3 && !w_dec_hi) ||
                    (bus.id_dst_lo && r_cnt_lo == 2'd3 && !w_dec_lo);

    assign w_stall = bus.id_valid && (w_blk_rs || w_blk_rt || w_blk_hi || w_blk_lo || w_full);
    assign w_issue = bus.id_valid && !w_stall;

    always_comb begin
        logic v_inc;
        logic v_dec;
        w_dec_err = 1'b0;
        for (int i = 1; i < 32; i++) begin
            v_inc = w_issue && bus.id_dst_rf && (bus.id_dst_idx == 5'(i));
            v_dec = bus.wb_retire && (w_tag_gpr == 5'(i));
            w_cnt_nxt[i] = f_cnt_step(r_cnt[i], v_inc, v_dec);
            if (v_dec && !v_inc && r_cnt[i] == 2'd0) w_dec_err = 1'b1;
        end
        w_cnt_hi_nxt = f_cnt_step(r_cnt_hi, w_issue && bus.id_dst_hi, w_dec_hi);
        w_cnt_lo_nxt = f_cnt_step(r_cnt_lo, w_issue && bus.id_dst_lo, w_dec_lo);
        if (w_dec_hi && !(w_issue && bus.id_dst_hi) && r_cnt_hi == 2'd0) w_dec_err = 1'b1;
        if (w_dec_lo && !(w_issue && bus.id_dst_lo) && r_cnt_lo == 2'd0) w_dec_err = 1'b1;
    end

    assign w_err = w_dec_err ||
                   ((bus.rf_wena || bus.hi_wena || bus.lo_wena) && !bus.wb_retire) ||
                   (bus.rf_wena && bus.rf_waddr != w_tag_gpr);

    always_comb begin
        bus.id_rs_data = 32'd0;
        bus.id_rt_data = 32'd0;
        if (bus.id_rs != 5'd0)
            bus.id_rs_data = (bus.rf_wena && bus.rf_waddr == bus.id_rs) ? bus.rf_wdata
                                                                        : r_gpr[bus.id_rs];
        if (bus.id_rt != 5'd0)
            bus.id_rt_data = (bus.rf_wena && bus.rf_waddr == bus.id_rt) ? bus.rf_wdata
                                                                        : r_gpr[bus.id_rt];
    end

    assign bus.id_hi_data = bus.hi_wena ? bus.hi_wdata : r_hi;
    assign bus.id_lo_data = bus.lo_wena ? bus.lo_wdata : r_lo;
    assign bus.id_stall   = w_stall;
    assign bus.sb_err     = r_sb_err;

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) r_cnt[i] <= 2'd0;
            r_cnt_hi <= 2'd0;
            r_cnt_lo <= 2'd0;
            r_sb_err <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_cnt_hi <= w_cnt_hi_nxt;
            r_cnt_lo <= w_cnt_lo_nxt;
            if (w_err) r_sb_err <= 1'b1;
        end
    end

    // NOTE: architectural state must read 0 after reset, so the register array is reset too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) r_gpr[i] <= 32'd0;
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (bus.rf_wena && bus.rf_waddr != 5'd0) r_gpr[bus.rf_waddr] <= bus.rf_wdata;
            if (bus.hi_wena) r_hi <= bus.hi_wdata;
            if (bus.lo_wena) r_lo <= bus.lo_wdata;
        end
    end

endmodule

// File: tb/tb_wb_scoreboard_rf.sv
// Directed bench: stimulus queues expected port values, a negedge monitor
// pops and compares them against the live DUT outputs.
module tb_wb_scoreboard_rf;

    typedef enum {S_STALL, S_RS, S_RT, S_HI, S_LO, S_ERR} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;
    exp_t q[$];

    wb_scoreboard_rf_if bus ();

    wb_scoreboard_rf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so they are sampled mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() != 0) begin
            e = q.pop_front();
            case (e.sel)
                S_STALL: act = {31'd0, bus.id_stall};
                S_RS:    act = bus.id_rs_data;
                S_RT:    act = bus.id_rt_data;
                S_HI:    act = bus.id_hi_data;
                S_LO:    act = bus.id_lo_data;
                default: act = {31'd0, bus.sb_err};
            endcase
            check(e.name, act, e.exp);
        end
    end

    task automatic idle();
        bus.id_valid   = 1'b0;
        bus.id_rs      = 5'd0;
        bus.id_rt      = 5'd0;
        bus.id_use_rs  = 1'b0;
        bus.id_use_rt  = 1'b0;
        bus.id_use_hi  = 1'b0;
        bus.id_use_lo  = 1'b0;
        bus.id_dst_rf  = 1'b0;
        bus.id_dst_idx = 5'd0;
        bus.id_dst_hi  = 1'b0;
        bus.id_dst_lo  = 1'b0;
        bus.wb_retire  = 1'b0;
        bus.wb_tag     = 7'd0;
        bus.rf_wena    = 1'b0;
        bus.hi_wena    = 1'b0;
        bus.lo_wena    = 1'b0;
        bus.rf_waddr   = 5'd0;
        bus.rf_wdata   = 32'd0;
        bus.hi_wdata   = 32'd0;
        bus.lo_wdata   = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue_dst(input logic [4:0] idx, input string name);
        bus.id_valid   = 1'b1;
        bus.id_dst_rf  = 1'b1;
        bus.id_dst_idx = idx;
        push_exp(name, S_STALL, 32'd0);
    endtask

    task automatic retire_gpr(input logic [4:0] idx, input logic wena, input logic [31:0] data);
        bus.wb_retire = 1'b1;
        bus.wb_tag    = {2'b00, idx};
        bus.rf_wena   = wena;
        bus.rf_waddr  = idx;
        bus.rf_wdata  = data;
    endtask

    task automatic read_rs(input logic [4:0] idx);
        bus.id_valid  = 1'b1;
        bus.id_rs     = idx;
        bus.id_use_rs = 1'b1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle();

        // Reset held with random activity on every input.
        repeat (4) begin
            @(posedge clk);
            #1;
            bus.id_valid   = 1'($urandom);
            bus.id_rs      = 5'($urandom);
            bus.id_rt      = 5'($urandom);
            bus.id_use_rs  = 1'($urandom);
            bus.id_dst_rf  = 1'($urandom);
            bus.id_dst_idx = 5'($urandom);
            bus.id_dst_hi  = 1'($urandom);
            bus.wb_retire  = 1'($urandom);
            bus.wb_tag     = 7'($urandom);
            bus.rf_wena    = 1'($urandom);
            bus.hi_wena    = 1'($urandom);
            bus.lo_wena    = 1'($urandom);
            bus.rf_waddr   = 5'($urandom);
            bus.rf_wdata   = $urandom;
            bus.hi_wdata   = $urandom;
            bus.lo_wdata   = $urandom;
        end
        step();
        #2 rst = 1'b1;
        bus.id_valid  = 1'b1;
        bus.id_rs     = 5'd7;
        bus.id_rt     = 5'd31;
        bus.id_use_rs = 1'b1;
        bus.id_use_rt = 1'b1;
        bus.id_use_hi = 1'b1;
        bus.id_use_lo = 1'b1;
        push_exp("reset_stall", S_STALL, 32'd0);
        push_exp("reset_rs", S_RS, 32'd0);
        push_exp("reset_rt", S_RT, 32'd0);
        push_exp("reset_hi", S_HI, 32'd0);
        push_exp("reset_lo", S_LO, 32'd0);
        push_exp("reset_err", S_ERR, 32'd0);

        // Write/read r5 with same-cycle bypass, then from storage; r0 ignores writes.
        step(); issue_dst(5'd5, "wr_issue_r5");
        step(); read_rs(5'd5); retire_gpr(5'd5, 1'b1, 32'hDEADBEEF);
        push_exp("wr_bypass_stall", S_STALL, 32'd0);
        push_exp("wr_bypass_rs", S_RS, 32'hDEADBEEF);
        step(); read_rs(5'd5); retire_gpr(5'd0, 1'b1, 32'h00001234);
        bus.id_use_rt = 1'b1;
        push_exp("wr_storage_rs", S_RS, 32'hDEADBEEF);
        push_exp("wr_storage_stall", S_STALL, 32'd0);
        push_exp("r0_bypass", S_RT, 32'd0);
        step(); bus.id_use_rt = 1'b1;
        push_exp("r0_storage", S_RT, 32'd0);
        push_exp("wr_err", S_ERR, 32'd0);

        // RAW hazard on r8.
        step(); issue_dst(5'd8, "raw_issue_r8");
        for (int i = 0; i < 3; i++) begin
            step(); read_rs(5'd8);
            push_exp("raw_stall", S_STALL, 32'd1);
        end
        step(); read_rs(5'd8); retire_gpr(5'd8, 1'b1, 32'h00000055);
        push_exp("raw_bypass_stall", S_STALL, 32'd0);
        push_exp("raw_bypass_rs", S_RS, 32'h00000055);
        step(); bus.id_rs = 5'd8;
        push_exp("raw_storage_rs", S_RS, 32'h00000055);
        push_exp("novalid_stall", S_STALL, 32'd0);

        // Saturation on r3.
        for (int i = 0; i < 3; i++) begin
            step(); issue_dst(5'd3, "sat_issue");
        end
        step(); bus.id_valid = 1'b1; bus.id_dst_rf = 1'b1; bus.id_dst_idx = 5'd3;
        push_exp("sat_full_stall", S_STALL, 32'd1);
        step(); issue_dst(5'd3, "sat_retire_issue"); retire_gpr(5'd3, 1'b0, 32'd0);
        step(); bus.id_valid = 1'b1; bus.id_dst_rf = 1'b1; bus.id_dst_idx = 5'd3;
        push_exp("sat_still_full", S_STALL, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); retire_gpr(5'd3, 1'b0, 32'd0);
        end
        step(); read_rs(5'd3);
        push_exp("sat_drained_stall", S_STALL, 32'd0);
        push_exp("sat_err", S_ERR, 32'd0);

        // Squashed HI writer.
        step(); bus.id_valid = 1'b1; bus.id_dst_hi = 1'b1;
        push_exp("sq_issue_hi", S_STALL, 32'd0);
        step(); bus.id_valid = 1'b1; bus.id_use_hi = 1'b1;
        push_exp("sq_pending_stall", S_STALL, 32'd1);
        step(); bus.id_valid = 1'b1; bus.id_use_hi = 1'b1;
        bus.wb_retire = 1'b1; bus.wb_tag = 7'h20;
        push_exp("sq_no_bypass_stall", S_STALL, 32'd1);
        push_exp("sq_hi_during", S_HI, 32'd0);
        step(); bus.id_valid = 1'b1; bus.id_use_hi = 1'b1;
        push_exp("sq_after_stall", S_STALL, 32'd0);
        push_exp("sq_hi_after", S_HI, 32'd0);
        push_exp("sq_err", S_ERR, 32'd0);

        // HI and LO written together.
        step(); bus.id_valid = 1'b1; bus.id_dst_hi = 1'b1; bus.id_dst_lo = 1'b1;
        push_exp("hl_issue", S_STALL, 32'd0);
        step(); bus.id_valid = 1'b1; bus.id_use_hi = 1'b1; bus.id_use_lo = 1'b1;
        bus.wb_retire = 1'b1; bus.wb_tag = 7'h60;
        bus.hi_wena = 1'b1; bus.hi_wdata = 32'hCAFEF00D;
        bus.lo_wena = 1'b1; bus.lo_wdata = 32'h0BADC0DE;
        push_exp("hl_bypass_stall", S_STALL, 32'd0);
        push_exp("hl_bypass_hi", S_HI, 32'hCAFEF00D);
        push_exp("hl_bypass_lo", S_LO, 32'h0BADC0DE);
        step();
        push_exp("hl_storage_hi", S_HI, 32'hCAFEF00D);
        push_exp("hl_storage_lo", S_LO, 32'h0BADC0DE);

        // Retire to an idle r9 raises the sticky error.
        step(); retire_gpr(5'd9, 1'b0, 32'd0);
        push_exp("err_before_edge", S_ERR, 32'd0);
        step(); push_exp("err_set", S_ERR, 32'd1);
        step(); push_exp("err_held", S_ERR, 32'd1);

        // Reset asserted mid-stall clears everything asynchronously.
        step(); issue_dst(5'd10, "rst_issue_r10");
        step(); read_rs(5'd10);
        push_exp("rst_pre_stall", S_STALL, 32'd1);
        step(); read_rs(5'd10); bus.id_rt = 5'd5;
        #2 rst = 1'b0;
        push_exp("rst_async_stall", S_STALL, 32'd0);
        push_exp("rst_async_err", S_ERR, 32'd0);
        push_exp("rst_async_rt", S_RT, 32'd0);
        push_exp("rst_async_hi", S_HI, 32'd0);
        step(); rst = 1'b1; read_rs(5'd10);
        push_exp("post_rst_stall", S_STALL, 32'd0);
        push_exp("post_rst_err", S_ERR, 32'd0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
